// File: rtl/bram_sp_pkg.sv
// Shared defaults and depth helper for the bram_sp storage primitive.
package bram_sp_pkg;

    localparam int unsigned BRAM_SP_DATA_W = 8;
    localparam int unsigned BRAM_SP_ADDR_W = 1;

    function automatic int unsigned bram_sp_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/bram_sp_outreg.sv
// Output pipeline register placed after the read register, async active-low reset.
module bram_sp_outreg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bram_sp.sv
// Simple-dual-address synchronous RAM, read-first on collision, output register reset only.
// Define BRAM_SP_OUTREG_EN to add a second output register stage (read latency 2).
module bram_sp
    import bram_sp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BRAM_SP_DATA_W,
    parameter int unsigned ADDR_WIDTH = BRAM_SP_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] d_out
);

    localparam int unsigned DEPTH = bram_sp_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_en_c;

    // Writes are dropped while reset is held so contents survive a reset pulse.
    assign wr_en_c = we & rst_n;

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr] <= d_in;
        end
    end

    // Read register sees the pre-write word, giving read-first collision behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

`ifdef BRAM_SP_OUTREG_EN
    bram_sp_outreg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outreg (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rd_q),
        .q    (d_out)
    );
`else
    assign d_out = rd_q;
`endif

endmodule

// File: tb/tb_bram_sp.sv
// Scoreboard bench for bram_sp: random traffic against an array model plus a 4-deep cascade.
module tb_bram_sp;

`ifdef BRAM_SP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    // Cascade: each stage delays by LAT+1 edges, stage 0 by LAT.
    localparam int CDLY = 4 * LAT + 3;

    typedef struct {
        int         e;
        bit         known;
        logic [7:0] v;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] rd_addr = '0;
    logic [0:0] wr_addr = '0;
    logic [7:0] d_in = '0;
    logic       we = 1'b0;
    logic [7:0] d_out;
    logic [7:0] casc_in = '0;
    logic [7:0] cd [5];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    ent_t q[$];
    ent_t cq[$];
    logic [7:0] mdl [2];
    bit         known [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_sp #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_addr(rd_addr),
        .wr_addr(wr_addr),
        .d_in   (d_in),
        .we     (we),
        .d_out  (d_out)
    );

    assign cd[0] = casc_in;
    for (genvar g = 0; g < 4; g++) begin : g_casc
        bram_sp #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) u_c (
            .clk    (clk),
            .rst_n  (rst_n),
            .rd_addr(1'b0),
            .wr_addr(1'b0),
            .d_in   (cd[g]),
            .we     (1'b1),
            .d_out  (cd[g+1])
        );
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
        end
    endtask

    // One cycle of traffic; expected read word and cascade feed go to the scoreboards.
    task automatic step(input bit w, input logic [0:0] wa, input logic [0:0] ra,
                        input logic [7:0] din, input logic [7:0] cin);
        ent_t ent;
        @(negedge clk);
        we = w; wr_addr = wa; rd_addr = ra; d_in = din; casc_in = cin;
        ent.e = cyc + 1;
        ent.known = known[ra];
        ent.v = mdl[ra];
        q.push_back(ent);
        if (w) begin
            mdl[wa] = din;
            known[wa] = 1'b1;
        end
        ent.known = 1'b1;
        ent.v = cin;
        cq.push_back(ent);
    endtask

    // Monitor: compare each output at the cycle the scoreboard says it is due.
    initial begin
        ent_t ent;
        forever begin
            @(negedge clk);
            #1;
            while (q.size() > 0 && q[0].e + LAT - 1 <= cyc) begin
                ent = q.pop_front();
                if (mon_en && ent.known && ent.e + LAT - 1 == cyc) check("rd", d_out, ent.v);
            end
            while (cq.size() > 0 && cq[0].e + CDLY <= cyc) begin
                ent = cq.pop_front();
                if (mon_en && ent.e + CDLY == cyc) check("casc", cd[4], ent.v);
            end
        end
    end

    initial begin
        known[0] = 1'b0;
        known[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_val", d_out, 8'h00);
        check("reset_casc", cd[4], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed: write/read, collision, hold; cascade fed 1..4.
        step(1'b1, 1'b1, 1'b0, 8'h3C, 8'h01);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h02);
        step(1'b1, 1'b0, 1'b1, 8'h11, 8'h03);
        step(1'b1, 1'b0, 1'b0, 8'h22, 8'h04);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h55, 8'h00);
        repeat (3) step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
        repeat (CDLY) step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        end

        // Reset mid-cycle: output clears at once, memory survives, writes during reset dropped.
        step(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00);
        repeat (CDLY + 2) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
        check("pre_rst", d_out, 8'hA5);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async", d_out, 8'h00);
        q.delete();
        cq.delete();
        @(negedge clk);
        we = 1'b1; wr_addr = 1'b0; d_in = 8'hEE; rd_addr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_hold", d_out, 8'h00);
        check("rst_hold_casc", cd[4], 8'h00);
        we = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h5A);
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        end
        repeat (CDLY + 2) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
